// File: rtl/input_event_arbiter_pkg.sv
// Shared types for the input event arbiter.
//   ev_type_t    : queued event kind (KEY, ENTER, BKSP)
//   gate_state_t : keyboard typematic gate state (ARMED, HELD)
//   lowest_set3  : one-hot of the lowest set bit of a 3-bit vector
package input_event_pkg;

    typedef enum logic [1:0] {
        KEY   = 2'd0,
        ENTER = 2'd1,
        BKSP  = 2'd2
    } ev_type_t;

    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } gate_state_t;

    localparam int EV_TYPE_W = 2;

    // Two's-complement trick: bits & -bits isolates the lowest set bit.
    function automatic logic [2:0] lowest_set3(input logic [2:0] bits);
        logic [2:0] oh;
        oh = bits & (~bits + 3'd1);
        return oh;
    endfunction

endpackage

// File: rtl/input_event_arbiter_if.sv
// Event output handshake between the arbiter (master) and its consumer (slave).
//   ev_valid_out : queue head valid
//   ev_ready_in  : consumer accepts the head
//   ev_type_out  : head event type
//   ev_char_out  : head character (zero for ENTER and BKSP)
interface input_event_arbiter_if
    import input_event_pkg::*;
#(
    parameter int CHAR_W = 16
) ();

    logic              ev_valid_out;
    logic              ev_ready_in;
    ev_type_t          ev_type_out;
    logic [CHAR_W-1:0] ev_char_out;

    modport master (
        output ev_valid_out,
        output ev_type_out,
        output ev_char_out,
        input  ev_ready_in
    );

    modport slave (
        input  ev_valid_out,
        input  ev_type_out,
        input  ev_char_out,
        output ev_ready_in
    );

endinterface

// File: rtl/input_event_arbiter_fifo.sv
// First-word-fall-through event queue.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_req   : write request; push_ok reports whether it was taken
//   pop_req    : consumer pop (ignored when empty)
//   wr_data    : word to write
//   rd_data    : head word, forced to zero when the queue is empty
//   count      : occupancy, not_empty : count != 0
// A full queue still accepts a push in a cycle that also pops.
module event_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_req,
    input  logic                       pop_req,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       push_ok,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Handshake qualification against the current occupancy.
    always_comb begin
        empty_s   = (count_r == '0);
        full_s    = (count_r == CNT_FULL);
        pop_ok_s  = pop_req && !empty_s;
        push_ok_s = push_req && (!full_s || pop_ok_s);
    end

    // Storage write; contents need no reset because the read side is gated by count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation, zero while empty.
    always_comb begin
        if (empty_s) begin
            rd_data = '0;
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

    assign push_ok   = push_ok_s;
    assign count     = count_r;
    assign not_empty = !empty_s;

endmodule

// File: rtl/input_event_arbiter.sv
// Merges keyboard pulses and debounced button levels into one event queue.
//   pixel_clk_in, rst_n_in : clock, asynchronous active-low reset
//   kb_*_in                : one-cycle keyboard pulses, kb_char_in valid with kb_key_in
//   btn_in                 : button levels [0] key, [1] enter, [2] backspace
//   sw_char_in             : character attached to button KEY events
//   ev_if                  : queue head handshake (master side)
//   fifo_count_out         : queue occupancy
//   overflow_out           : sticky, set when an event was refused by a full queue
// Keyboard candidates always win the queue write port; buttons are latched as
// pending bits and drained one per free cycle, lowest index first.
module input_event_arbiter
    import input_event_pkg::*;
#(
    parameter int CHAR_W        = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter bit GATE_ON_BREAK = 1'b1
) (
    input  logic                            pixel_clk_in,
    input  logic                            rst_n_in,
    input  logic                            kb_key_in,
    input  logic                            kb_enter_in,
    input  logic                            kb_bksp_in,
    input  logic                            kb_break_in,
    input  logic [CHAR_W-1:0]               kb_char_in,
    input  logic [2:0]                      btn_in,
    input  logic [CHAR_W-1:0]               sw_char_in,
    input_event_arbiter_if.master           ev_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_out,
    output logic                            overflow_out
);

    localparam int EV_W = EV_TYPE_W + CHAR_W;

    gate_state_t       state_r;
    gate_state_t       state_nxt_s;
    logic              kb_any_s;
    logic              kb_break_only_s;
    logic              kb_cand_s;
    ev_type_t          kb_type_s;
    logic [CHAR_W-1:0] kb_char_s;
    logic [2:0]        btn_prev_r;
    logic [2:0]        btn_edge_s;
    logic [2:0]        pend_r;
    logic [2:0]        pend_nxt_s;
    logic [2:0]        drain_oh_s;
    logic              btn_push_s;
    ev_type_t          btn_type_s;
    logic [CHAR_W-1:0] btn_char_s;
    logic              push_req_s;
    logic              push_ok_s;
    logic [EV_W-1:0]   push_data_s;
    logic [EV_W-1:0]   head_s;
    logic              not_empty_s;
    logic              pop_s;
    logic              overflow_r;

    // Keyboard priority select: key > enter > bksp; break only counts when alone.
    always_comb begin
        kb_any_s        = kb_key_in || kb_enter_in || kb_bksp_in;
        kb_break_only_s = kb_break_in && !kb_any_s;
        if (kb_key_in) begin
            kb_type_s = KEY;
            kb_char_s = kb_char_in;
        end else if (kb_enter_in) begin
            kb_type_s = ENTER;
            kb_char_s = '0;
        end else if (kb_bksp_in) begin
            kb_type_s = BKSP;
            kb_char_s = '0;
        end else begin
            kb_type_s = KEY;
            kb_char_s = '0;
        end
    end

    // Gate FSM next state: a taken pulse in HELD is dropped without flagging overflow.
    always_comb begin
        state_nxt_s = state_r;
        kb_cand_s   = 1'b0;
        case (state_r)
            ARMED: begin
                if (kb_any_s) begin
                    kb_cand_s = 1'b1;
                    if (GATE_ON_BREAK) begin
                        state_nxt_s = HELD;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            HELD: begin
                if (kb_break_only_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            default: begin
                state_nxt_s = ARMED;
            end
        endcase
    end

    // Button edge detect and pending drain in cycles the keyboard leaves free.
    always_comb begin
        btn_edge_s = btn_in & ~btn_prev_r;
        if (kb_cand_s) begin
            drain_oh_s = 3'b000;
        end else begin
            drain_oh_s = lowest_set3(pend_r);
        end
        btn_push_s = |drain_oh_s;
        // A drained bit clears even if the queue refuses it.
        pend_nxt_s = (pend_r & ~drain_oh_s) | btn_edge_s;
        case (drain_oh_s)
            3'b010: begin
                btn_type_s = ENTER;
                btn_char_s = '0;
            end
            3'b100: begin
                btn_type_s = BKSP;
                btn_char_s = '0;
            end
            default: begin
                btn_type_s = KEY;
                btn_char_s = sw_char_in;
            end
        endcase
    end

    // Queue write port mux.
    always_comb begin
        push_req_s = kb_cand_s || btn_push_s;
        if (kb_cand_s) begin
            push_data_s = {kb_type_s, kb_char_s};
        end else begin
            push_data_s = {btn_type_s, btn_char_s};
        end
        pop_s = not_empty_s && ev_if.ev_ready_in;
    end

    // Gate state, button history and pending bits; history resets high so held buttons stay silent.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= ARMED;
            btn_prev_r <= 3'b111;
            pend_r     <= 3'b000;
        end else begin
            state_r    <= state_nxt_s;
            btn_prev_r <= btn_in;
            pend_r     <= pend_nxt_s;
        end
    end

    // Sticky overflow on any refused push.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overflow_r <= 1'b0;
        end else if (push_req_s && !push_ok_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pixel_clk_in),
        .rst_n     (rst_n_in),
        .push_req  (push_req_s),
        .pop_req   (pop_s),
        .wr_data   (push_data_s),
        .push_ok   (push_ok_s),
        .rd_data   (head_s),
        .count     (fifo_count_out),
        .not_empty (not_empty_s)
    );

    assign ev_if.ev_valid_out = not_empty_s;
    assign ev_if.ev_type_out  = ev_type_t'(head_s[EV_W-1 -: EV_TYPE_W]);
    assign ev_if.ev_char_out  = head_s[CHAR_W-1:0];
    assign overflow_out       = overflow_r;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Directed bench for input_event_arbiter with a scoreboard: stimulus pushes the
// expected {type, char} words, an independent monitor pops and compares them
// whenever the DUT hands an event to the consumer.
module tb_input_event_arbiter;
    import input_event_pkg::*;

    localparam int CHAR_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_s       = 1'b0;
    logic              rst_n_s     = 1'b0;
    logic              kb_key_s    = 1'b0;
    logic              kb_enter_s  = 1'b0;
    logic              kb_bksp_s   = 1'b0;
    logic              kb_break_s  = 1'b0;
    logic [CHAR_W-1:0] kb_char_s   = 16'h0000;
    logic [2:0]        btn_s       = 3'b000;
    logic [CHAR_W-1:0] sw_char_s   = 16'h0000;
    logic [CNT_W-1:0]  count_s;
    logic              overflow_s;

    input_event_arbiter_if #(.CHAR_W(CHAR_W)) ev_if ();

    input_event_arbiter #(
        .CHAR_W        (CHAR_W),
        .FIFO_DEPTH    (DEPTH),
        .GATE_ON_BREAK (1'b1)
    ) dut (
        .pixel_clk_in   (clk_s),
        .rst_n_in       (rst_n_s),
        .kb_key_in      (kb_key_s),
        .kb_enter_in    (kb_enter_s),
        .kb_bksp_in     (kb_bksp_s),
        .kb_break_in    (kb_break_s),
        .kb_char_in     (kb_char_s),
        .btn_in         (btn_s),
        .sw_char_in     (sw_char_s),
        .ev_if          (ev_if),
        .fifo_count_out (count_s),
        .overflow_out   (overflow_s)
    );

    always #5 clk_s = ~clk_s;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_ev_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic kb_pulse(input logic key, input logic enter, input logic bksp,
                            input logic brk, input logic [CHAR_W-1:0] ch);
        kb_key_s   = key;
        kb_enter_s = enter;
        kb_bksp_s  = bksp;
        kb_break_s = brk;
        kb_char_s  = ch;
        tick();
        kb_key_s   = 1'b0;
        kb_enter_s = 1'b0;
        kb_bksp_s  = 1'b0;
        kb_break_s = 1'b0;
        kb_char_s  = 16'h0000;
    endtask

    task automatic drain();
        ev_if.ev_ready_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!ev_if.ev_valid_out) break;
        end
        ev_if.ev_ready_in = 1'b0;
        check("drain_done", 32'(ev_if.ev_valid_out), 32'd0);
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge clk_s) begin
        if (rst_n_s && ev_if.ev_valid_out && ev_if.ev_ready_in) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_ev_s = exp_q.pop_front();
                check("ev_type", 32'(ev_if.ev_type_out), 32'(mon_ev_s[17:16]));
                check("ev_char", 32'(ev_if.ev_char_out), 32'(mon_ev_s[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_if.ev_ready_in = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(ev_if.ev_valid_out), 32'd0);
        check("rst_count", 32'(count_s), 32'd0);
        check("rst_overflow", 32'(overflow_s), 32'd0);
        check("rst_type", 32'(ev_if.ev_type_out), 32'd0);
        check("rst_char", 32'(ev_if.ev_char_out), 32'd0);
        rst_n_s = 1'b1;
        tick();

        // Single keyboard key into an empty queue: visible one cycle later.
        exp_q.push_back({KEY, 16'h0041});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0041);
        check("key_valid", 32'(ev_if.ev_valid_out), 32'd1);
        check("key_type", 32'(ev_if.ev_type_out), 32'd0);
        check("key_char", 32'(ev_if.ev_char_out), 32'h0041);
        check("key_count", 32'(count_s), 32'd1);
        drain();
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Typematic gate: key, key(dropped), break, key.
        exp_q.push_back({KEY, 16'h0061});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0061);
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0062);
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        exp_q.push_back({KEY, 16'h0063});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0063);
        check("gate_count", 32'(count_s), 32'd2);
        check("gate_overflow", 32'(overflow_s), 32'd0);
        drain();
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Keyboard enter beats buttons; buttons drain lowest first, KEY takes sw_char at push time.
        exp_q.push_back({ENTER, 16'h0000});
        exp_q.push_back({KEY, 16'h5678});
        exp_q.push_back({BKSP, 16'h0000});
        sw_char_s  = 16'h1234;
        kb_enter_s = 1'b1;
        btn_s      = 3'b101;
        tick();
        kb_enter_s = 1'b0;
        sw_char_s  = 16'h5678;
        check("mix_count0", 32'(count_s), 32'd1);
        tick();
        check("mix_count1", 32'(count_s), 32'd2);
        tick();
        check("mix_count2", 32'(count_s), 32'd3);
        tick();
        check("btn_hold_no_repeat", 32'(count_s), 32'd3);
        drain();
        btn_s = 3'b000;
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Fill past depth: ninth key is refused and flags overflow.
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) exp_q.push_back({KEY, 16'(16'h0100 + i)});
            kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i));
            kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        end
        check("full_count", 32'(count_s), 32'd8);
        check("full_overflow", 32'(overflow_s), 32'd1);
        // Push and pop together on a full queue.
        exp_q.push_back({KEY, 16'h0200});
        ev_if.ev_ready_in = 1'b1;
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
        ev_if.ev_ready_in = 1'b0;
        check("full_pushpop_count", 32'(count_s), 32'd8);
        drain();
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("overflow_sticky", 32'(overflow_s), 32'd1);

        // Reset mid-operation with three events queued and a button held through it.
        exp_q.push_back({KEY, 16'h0031});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0031);
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        exp_q.push_back({KEY, 16'h0032});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0032);
        kb_pulse(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        exp_q.push_back({KEY, 16'h0033});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0033);
        check("pre_reset_count", 32'(count_s), 32'd3);
        rst_n_s = 1'b0;
        btn_s   = 3'b010;
        #1;
        check("mid_rst_valid", 32'(ev_if.ev_valid_out), 32'd0);
        check("mid_rst_count", 32'(count_s), 32'd0);
        check("mid_rst_overflow", 32'(overflow_s), 32'd0);
        exp_q.delete();
        tick();
        rst_n_s = 1'b1;
        tick();
        tick();
        tick();
        check("btn_held_through_reset", 32'(count_s), 32'd0);
        // FSM must be ARMED again: a key is accepted without a preceding break.
        exp_q.push_back({KEY, 16'h0077});
        kb_pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0077);
        check("post_rst_armed", 32'(count_s), 32'd1);
        drain();
        btn_s = 3'b000;
        tick();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/input_event_arbiter.md
INPUT_EVENT_ARBITER -- requirements
Module: input_event_arbiter

Interface
REQ-001 SHALL take parameter CHAR_W, default 16, width of the character field.
REQ-002 SHALL take parameter FIFO_DEPTH, default 8, event queue depth; must be a power of two and at least 2.
REQ-003 SHALL take parameter GATE_ON_BREAK, default 1; 1 enables typematic-repeat suppression, 0 passes every keyboard event.
REQ-004 SHALL have one clock and an asynchronous active-low reset; all logic on the rising edge of pixel_clk_in.
REQ-005 pixel_clk_in  in  1  pixel clock.
REQ-006 rst_n_in  in  1  asynchronous active-low reset.
REQ-007 kb_key_in, kb_enter_in, kb_bksp_in, kb_break_in  in  1 each  one-cycle keyboard event pulses.
REQ-008 kb_char_in  in  CHAR_W  translated keyboard character, valid with kb_key_in.
REQ-009 btn_in  in  3  debounced button levels: [0] key, [1] enter, [2] backspace.
REQ-010 sw_char_in  in  CHAR_W  character attached to button key events.
REQ-011 ev_valid_out  out  1  queue head valid.
REQ-012 ev_ready_in  in  1  consumer accepts the head.
REQ-013 ev_type_out  out  2  head type: 0 KEY, 1 ENTER, 2 BKSP.
REQ-014 ev_char_out  out  CHAR_W  head character; zero for ENTER and BKSP.
REQ-015 fifo_count_out  out  $clog2(FIFO_DEPTH+1)  occupancy.
REQ-016 overflow_out  out  1  sticky flag: an event was dropped.

Function
REQ-017 Keyboard arbitration: exactly one kb pulse is taken per cycle, with priority key > enter > bksp > break; lower-priority pulses in the same cycle are discarded.
REQ-018 Gate FSM (GATE_ON_BREAK=1) has two states. ARMED: a key, enter or bksp pulse becomes a candidate and the FSM moves to HELD. HELD: key, enter and bksp pulses are dropped without setting overflow; break moves the FSM to ARMED. Break in ARMED has no effect.
REQ-019 With GATE_ON_BREAK=0, the FSM stays ARMED and every key, enter or bksp pulse becomes a candidate.
REQ-020 Button rising edge (current level 1, previous-cycle level 0) sets a pending bit per button. Pending bits drain one per cycle, lowest index first, only in cycles with no keyboard candidate. A pending bit that is already set absorbs a repeat edge.
REQ-021 A button KEY event carries sw_char_in sampled in its push cycle; a keyboard KEY event carries kb_char_in sampled in its pulse cycle.
REQ-022 Push is accepted when fifo_count_out < FIFO_DEPTH, or when the queue is full and a pop occurs in the same cycle.
REQ-023 When a push is refused, the event is dropped and overflow_out is set to 1, remaining 1 until reset. A drained button pending bit clears even when its push is refused.
REQ-024 Queue is first-word-fall-through. ev_valid_out = (count != 0). Pop occurs when ev_valid_out and ev_ready_in are both high. Latency from event to ev_valid_out on an empty queue is exactly 1 cycle.
REQ-025 Simultaneous push and pop leaves the count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 While rst_n_in=0: count 0, pointers 0, ev_valid_out 0, overflow_out 0, pending bits 0, gate FSM ARMED, ev_type_out 0, ev_char_out 0.
REQ-027 Previous-button registers reset to 1, so a button held through reset release produces no event.
REQ-028 Reset asserted mid-operation discards all queued and pending events immediately, with no partial pop.

Structure
REQ-029 Package input_event_pkg SHALL hold the ev_type_t enum (KEY, ENTER, BKSP) and the gate_state_t enum (ARMED, HELD).
REQ-030 Queue storage SHALL be one sub-module, event_fifo, parametrised on width and depth.

Verification
REQ-031 Empty queue, ev_ready_in=0, kb_key_in pulse with kb_char_in=16'h0041 -> next cycle ev_valid_out=1, type 0, char 16'h0041, count 1.
REQ-032 GATE_ON_BREAK=1, key pulse, key pulse, break, key pulse -> exactly 2 events queued; overflow_out stays 0.
REQ-033 kb_enter_in pulse in the same cycle as btn_in rising 3'b101 -> queue order ENTER, KEY (char sw_char_in), BKSP on consecutive cycles.
REQ-034 FIFO_DEPTH=8, ev_ready_in=0, 9 accepted-kind pulses -> count 8, overflow_out=1. Then a push and pop in the same cycle -> count stays 8.
REQ-035 Queue holding 3 events, rst_n_in low for 1 cycle -> ev_valid_out=0, count 0, overflow_out 0, FSM ARMED. A btn_in held high throughout reset -> no event.
